// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported synchronous data memory between the
// CPU load/store path and a DMA/loader requester.
// Latency: the grant is combinational, so the address reaches memory in the
// grant cycle, and read data returns one cycle later on the owner's port.
// Backpressure: a CPU that loses arbitration sees cpu_stall and holds its
// request. The DMA holds its request until dma_gnt.
// Ports: clk/reset (async active-low), cpu_* request side plus
// stall/rdata/rvalid, dma_* request side plus gnt/rdata/rvalid, and mem_* to
// the data memory.
// Optional macro DMEM_ARB_LOCK_EN: the DMA can hold ownership back-to-back
// through dma_lock, for up to LOCK_MAX locked grants.
module dmem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int ADDRW    = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [ADDRW-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_stall,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_rvalid,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [ADDRW-1:0] dma_addr,
  input  logic [WIDTH-1:0] dma_wdata,
  input  logic             dma_lock,
  output logic             dma_gnt,
  output logic [WIDTH-1:0] dma_rdata,
  output logic             dma_rvalid,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  // last: 0 = CPU was granted last, 1 = DMA was granted last
  logic last_q, last_d;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;   // 0 = CPU, 1 = DMA
  logic cpu_gnt, dma_gnt_w;

`ifdef DMEM_ARB_LOCK_EN
  localparam int LCW = $clog2(LOCK_MAX + 1);
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           lock_force;
  logic           lock_hold;

  // Once the lock budget is spent, the next CPU request overrides the lock.
  assign lock_force = (lock_cnt_q == LCW'(LOCK_MAX)) & cpu_req;
  assign lock_hold  = last_q & dma_lock & dma_req & ~lock_force;
`else
  logic unused_lock;
  assign unused_lock = dma_lock & (LOCK_MAX > 0);
`endif

  // Grants are held low while reset is asserted, so nothing reaches memory
  // during reset even when both sides are requesting.
  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt_w = 1'b0;
    if (reset) begin
`ifdef DMEM_ARB_LOCK_EN
      if (lock_force) begin
        cpu_gnt = 1'b1;
      end else if (lock_hold) begin
        dma_gnt_w = 1'b1;
      end else
`endif
      if (cpu_req && dma_req) begin
        cpu_gnt   = last_q;
        dma_gnt_w = ~last_q;
      end else begin
        cpu_gnt   = cpu_req;
        dma_gnt_w = dma_req;
      end
    end
  end

  always_comb begin
    last_d     = last_q;
    rd_owner_d = rd_owner_q;
    if (cpu_gnt) begin
      last_d     = 1'b0;
      rd_owner_d = 1'b0;
    end else if (dma_gnt_w) begin
      last_d     = 1'b1;
      rd_owner_d = 1'b1;
    end
    rd_pend_d = (cpu_gnt & ~cpu_we) | (dma_gnt_w & ~dma_we);
  end

`ifdef DMEM_ARB_LOCK_EN
  // Count grants that continue a DMA ownership run. Saturate at the budget
  // so that a DMA-only phase cannot wrap the counter.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (cpu_gnt || !dma_lock) begin
      lock_cnt_d = '0;
    end else if (dma_gnt_w && last_q && (lock_cnt_q != LCW'(LOCK_MAX))) begin
      lock_cnt_d = lock_cnt_q + LCW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lock_cnt_q <= '0;
    else        lock_cnt_q <= lock_cnt_d;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q     <= 1'b1;   // CPU wins the first contested cycle
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Memory mux: the winner drives memory. Outputs are zero when nobody is
  // granted.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt_w) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // The stall is also gated by reset so that every output is quiet in reset.
  assign cpu_stall  = reset & cpu_req & ~cpu_gnt;
  assign dma_gnt    = dma_gnt_w;

  assign cpu_rvalid = rd_pend_q & ~rd_owner_q;
  assign dma_rvalid = rd_pend_q & rd_owner_q;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported synchronous data memory between the CPU load/store path and a DMA/loader requester. Sits between the CPU's `memwrite`/`aluout`/`writedata`/`readdata` signals and the data memory. When the CPU loses arbitration it is stalled. The DMA side uses a request/grant handshake.

## Interface
Parameters:
- `WIDTH`, 32, data width
- `ADDRW`, 32, address width
- `LOCK_MAX`, 16, maximum consecutive locked DMA grants (used only with the lock feature)

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU memory access this cycle
- `cpu_we`  in  1  CPU write enable
- `cpu_addr`  in  ADDRW  CPU address
- `cpu_wdata`  in  WIDTH  CPU write data
- `cpu_stall`  out  1  CPU must hold its request and freeze its PC
- `cpu_rdata`  out  WIDTH  CPU read data
- `cpu_rvalid`  out  1  `cpu_rdata` is valid this cycle
- `dma_req`  in  1  DMA access request
- `dma_we`  in  1  DMA write enable
- `dma_addr`  in  ADDRW  DMA address
- `dma_wdata`  in  WIDTH  DMA write data
- `dma_lock`  in  1  DMA requests back-to-back ownership
- `dma_gnt`  out  1  DMA access accepted this cycle
- `dma_rdata`  out  WIDTH  DMA read data
- `dma_rvalid`  out  1  `dma_rdata` is valid this cycle
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDRW  memory address
- `mem_wdata`  out  WIDTH  memory write data
- `mem_rdata`  in  WIDTH  memory read data, one cycle after the address

## Operation
- Grant logic is combinational from the requests and the registered state. At most one grant per cycle.
- `cpu_gnt` is internal. `cpu_stall` = `cpu_req & ~cpu_gnt`.
- If only one side requests, that side is granted.
- If both sides request, round-robin applies: the side not recorded in the `last` register wins.
- `last` updates on every grant to the granted side.
- The memory mux drives the winner's address, write data and write enable.
  - With no grant: `mem_we` = 0, `mem_addr`/`mem_wdata` = 0.
  - `mem_we` is never high unless some side is granted with its `we` = 1.
- Read return:
  - A granted read registers its owner.
  - The next cycle, the owner's `rvalid` pulses for one cycle and its `rdata` = `mem_rdata`.
  - The non-owner's `rdata` = 0.
  - Writes produce no `rvalid`.
- State: `last` (0 = CPU, 1 = DMA), `rd_owner`/`rd_pend` registers, and the lock counter `lock_cnt`, which is `$clog2(LOCK_MAX+1)` bits wide.

## Timing
- Reset (asynchronous assert, `reset` = 0):
  - `last` = DMA, so the CPU wins the first contested cycle.
  - `rd_pend` = 0, `lock_cnt` = 0.
  - `cpu_rvalid` = `dma_rvalid` = 0, `dma_gnt` = 0, `mem_we` = 0.
- Deassertion is synchronised to `clk` by the reset synchroniser upstream.
- Reset asserted mid-read: the pending `rvalid` is dropped and never appears.
- Grant-to-memory latency: 0 cycles; address is presented in the grant cycle.
- Read latency: 1 cycle (grant at edge N, `rvalid` at cycle N+1).
- Back-to-back grants are allowed every cycle. A read return in cycle N+1 can coincide with a new grant in N+1.
- Requesters must hold `req`/`we`/`addr`/`wdata` stable until granted. The CPU does this via `cpu_stall`; the DMA does it until `dma_gnt`.
- Sustained contention alternates strictly, giving 50% throughput per side.

## Configuration
- Macro: `DMEM_ARB_LOCK_EN`.
- Defined:
  - When the previous grant went to the DMA and `dma_lock` and `dma_req` are both high, the DMA keeps the grant regardless of `cpu_req`.
  - `lock_cnt` increments on each locked grant.
  - When `lock_cnt` reaches `LOCK_MAX`, the next cycle with `cpu_req` high is forced to the CPU and `lock_cnt` clears.
  - `lock_cnt` also clears on any CPU grant or when `dma_lock` = 0.
- Undefined: the `dma_lock` port still exists but is ignored, `lock_cnt` is not built, and arbitration is pure round-robin.

## Test plan
- **Reset:** with `reset` = 0 and both requests high → all outputs 0 and no `mem_we`. Release reset, both reads to 0x10/0x20 → CPU is granted first (`mem_addr` = 0x10), DMA granted the next cycle.
- **Solo CPU read:** `cpu_req` = 1, `cpu_addr` = 0x40, memory returns 0xDEADBEEF → `cpu_stall` = 0, and `cpu_rvalid` = 1 with `cpu_rdata` = 0xDEADBEEF one cycle later. `dma_rvalid` stays 0.
- **Contention:** both sides write continuously for 6 cycles → grants alternate C,D,C,D,C,D. `cpu_stall` is high on D cycles. `mem_wdata` matches the winner each cycle.
- **Mixed traffic:** CPU read, DMA write and CPU read in consecutive cycles → each `rvalid` arrives on the correct port one cycle after its grant, and the write produces no `rvalid`.
- **Lock (`DMEM_ARB_LOCK_EN`, `LOCK_MAX` = 4):** DMA locked with the CPU requesting → 4 locked DMA grants after the initial DMA grant, then a forced CPU grant. Without the macro, the same stimulus alternates.
- **Mid-read reset:** assert `reset` the cycle after a DMA read grant → `dma_rvalid` never asserts, and state returns to reset values.
